// File: rtl/data_mem_resp_if.sv
// Load/store bus between the core (master) and the data memory responder (slave):
// a request channel and a response channel, each with its own valid/ready handshake.
interface data_mem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Single-port data memory responder with RISC-V load/store sizing and fixed wait states.
// DATA_MEM_MISALIGN_TRAP_EN: misaligned accesses raise rsp_err instead of being force-aligned.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | counting down wait states; access happens when the counter hits 0
// RESP  | rsp_valid high, holding the response until rsp_ready
module data_mem_resp #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  data_mem_resp_if.slave   bus
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                capture, do_access;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          f3_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic [31:0]         mem [0:DEPTH-1];
  logic [ADDR_W-3:0]   idx;
  logic [1:0]          size, off, off_eff;
  logic                legal, trap, err_c, mem_we;
  logic [4:0]          sh;
  logic [31:0]         rd_word, mask, wr_word, rdata_c;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr[ADDR_W-1:0];
        f3_q    <= bus.req_funct3;
        wdata_q <= bus.req_wdata;
      end
      if (do_access) begin
        rdata_q <= rdata_c;
        err_q   <= err_c;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          capture = 1'b1;
          cnt_d   = 3'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Size/sign decode and lane placement for the captured request.
  always_comb begin
    size = f3_q[1:0];
    off  = addr_q[1:0];
    idx  = addr_q[ADDR_W-1:2];
    if (we_q) legal = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
    else      legal = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
                      (f3_q == 3'b100) || (f3_q == 3'b101);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    trap    = ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
    off_eff = off;
`else
    trap    = 1'b0;
    if (size == 2'b01)      off_eff = {off[1], 1'b0};
    else if (size == 2'b10) off_eff = 2'b00;
    else                    off_eff = off;
`endif
    err_c   = !legal || trap;
    sh      = {off_eff, 3'b000};
    rd_word = mem[idx];
    rd_byte = rd_word[sh +: 8];
    rd_half = rd_word[{off_eff[1], 4'b0000} +: 16];

    rdata_c = '0;
    if (!err_c && !we_q) begin
      case (f3_q)
        3'b000:  rdata_c = {{24{rd_byte[7]}}, rd_byte};
        3'b001:  rdata_c = {{16{rd_half[15]}}, rd_half};
        3'b010:  rdata_c = rd_word;
        3'b100:  rdata_c = {24'h0, rd_byte};
        3'b101:  rdata_c = {16'h0, rd_half};
        default: rdata_c = '0;
      endcase
    end

    case (size)
      2'b00:   mask = 32'h0000_00FF << sh;
      2'b01:   mask = 32'h0000_FFFF << sh;
      default: mask = 32'hFFFF_FFFF;
    endcase
    wr_word = (rd_word & ~mask) | ((wdata_q << sh) & mask);
    mem_we  = do_access && we_q && !err_c;
  end

  // Array has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wr_word;
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: vector table plus backpressure and mid-wait reset sequences.
module tb_data_mem_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst3_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  data_mem_resp_if bus();
  data_mem_resp_if bus3();

  data_mem_resp #(.ADDR_W(12), .LATENCY(2)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus.slave));
  data_mem_resp #(.ADDR_W(12), .LATENCY(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(bus3.slave));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam logic [31:0] EXP_LW11 = 32'h0;
  localparam logic        ERR_MIS  = 1'b1;
  localparam logic [31:0] EXP_FIN  = 32'hCAFE_F00D;
`else
  localparam logic [31:0] EXP_LW11 = 32'h8001_BEEF;
  localparam logic        ERR_MIS  = 1'b0;
  localparam logic [31:0] EXP_FIN  = 32'h1234_F00D;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [2:0] f3,
                              input logic [31:0] wd, input logic [31:0] rd, input logic er);
    vec_t v;
    v.we = we; v.addr = a; v.f3 = f3; v.wdata = wd; v.exp_rd = rd; v.exp_err = er;
    return v;
  endfunction

  task automatic txn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat);
    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_we = we; bus.req_addr = addr; bus.req_funct3 = f3; bus.req_wdata = wd;
    bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic txn3(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    @(negedge clk);
    bus3.req_we = we; bus3.req_addr = addr; bus3.req_funct3 = f3; bus3.req_wdata = wd;
    bus3.req_valid = 1'b1; bus3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    lat = 0;
    while (!bus3.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus3.rsp_rdata;
    er = bus3.rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, r0;
    logic        er, e0;
    int          lat;

    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_funct3 = 0;
    bus.req_wdata = 0; bus.rsp_ready = 1;
    bus3.req_valid = 0; bus3.req_we = 0; bus3.req_addr = 0; bus3.req_funct3 = 0;
    bus3.req_wdata = 0; bus3.rsp_ready = 1;

    vecs.push_back(mk(1, 32'h10,   3'b010, 32'hDEAD_BEEF, 32'h0,         0));
    vecs.push_back(mk(0, 32'h10,   3'b010, 32'h0,         32'hDEAD_BEEF, 0));
    vecs.push_back(mk(1, 32'h13,   3'b000, 32'h1234_5680, 32'h0,         0));
    vecs.push_back(mk(0, 32'h13,   3'b000, 32'h0,         32'hFFFF_FF80, 0));
    vecs.push_back(mk(0, 32'h13,   3'b100, 32'h0,         32'h0000_0080, 0));
    vecs.push_back(mk(0, 32'h10,   3'b010, 32'h0,         32'h80AD_BEEF, 0));
    vecs.push_back(mk(1, 32'h12,   3'b001, 32'hAAAA_8001, 32'h0,         0));
    vecs.push_back(mk(0, 32'h12,   3'b001, 32'h0,         32'hFFFF_8001, 0));
    vecs.push_back(mk(0, 32'h12,   3'b101, 32'h0,         32'h0000_8001, 0));
    vecs.push_back(mk(0, 32'h10,   3'b010, 32'h0,         32'h8001_BEEF, 0));
    vecs.push_back(mk(0, 32'h10,   3'b011, 32'h0,         32'h0,         1));
    vecs.push_back(mk(0, 32'h11,   3'b010, 32'h0,         EXP_LW11,      ERR_MIS));
    vecs.push_back(mk(1, 32'h10,   3'b011, 32'hFFFF_FFFF, 32'h0,         1));
    vecs.push_back(mk(0, 32'h10,   3'b010, 32'h0,         32'h8001_BEEF, 0));
    vecs.push_back(mk(0, 32'h10,   3'b110, 32'h0,         32'h0,         1));
    vecs.push_back(mk(1, 32'h1010, 3'b010, 32'hCAFE_F00D, 32'h0,         0));
    vecs.push_back(mk(0, 32'h10,   3'b010, 32'h0,         32'hCAFE_F00D, 0));
    vecs.push_back(mk(0, 32'h11,   3'b000, 32'h0,         32'hFFFF_FFF0, 0));
    vecs.push_back(mk(0, 32'h12,   3'b101, 32'h0,         32'h0000_CAFE, 0));
    vecs.push_back(mk(1, 32'h13,   3'b001, 32'h5555_1234, 32'h0,         ERR_MIS));
    vecs.push_back(mk(0, 32'h10,   3'b010, 32'h0,         EXP_FIN,       0));

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    rst_n = 1'b1;
    rst3_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_idle", i), 32'(bus.req_ready), 32'd1);
    end

    // Backpressure with a second request already waiting.
    @(negedge clk);
    bus.req_we = 0; bus.req_addr = 32'h10; bus.req_funct3 = 3'b010;
    bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_addr = 32'h12; bus.req_funct3 = 3'b101;
    chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd2);
    r0 = bus.rsp_rdata;
    e0 = bus.rsp_err;
    chk("bp_rdata", r0, EXP_FIN);
    chk("bp_err", 32'(e0), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp_hold%0d_rdata", k), bus.rsp_rdata, r0);
      chk($sformatf("bp_hold%0d_err", k), 32'(bus.rsp_err), 32'(e0));
      chk($sformatf("bp_hold%0d_ready", k), 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_hs_bubble", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_second_accept", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp2_latency", 32'(lat), 32'd2);
    chk("bp2_rdata", bus.rsp_rdata, {16'h0, EXP_FIN[31:16]});
    @(posedge clk); #1;

    // LATENCY=3: reset during WAIT discards the pending store.
    txn3(1, 32'h20, 3'b010, 32'hA5A5_A5A5, rd, er, lat);
    chk("l3_pre_latency", 32'(lat), 32'd3);
    chk("l3_pre_err", 32'(er), 32'd0);
    @(negedge clk);
    bus3.req_we = 1; bus3.req_addr = 32'h20; bus3.req_funct3 = 3'b010;
    bus3.req_wdata = 32'h1234_5678; bus3.req_valid = 1'b1;
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    @(posedge clk); #1;
    rst3_n = 1'b0;
    #1;
    chk("l3_rst_valid", 32'(bus3.rsp_valid), 32'd0);
    chk("l3_rst_ready", 32'(bus3.req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("l3_rst_hold_valid", 32'(bus3.rsp_valid), 32'd0);
    chk("l3_rst_hold_rdata", bus3.rsp_rdata, 32'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("l3_after_valid", 32'(bus3.rsp_valid), 32'd0);
    txn3(0, 32'h20, 3'b010, 32'h0, rd, er, lat);
    chk("l3_lw_latency", 32'(lat), 32'd3);
    chk("l3_lw_rdata", rd, 32'hA5A5_A5A5);
    chk("l3_lw_err", 32'(er), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Single-port data memory that acts as the responder on the core's load/store bus. It accepts one request at a time from the core (the initiator) over a valid/ready handshake. It applies RISC-V size and sign rules taken from the load/store `funct3`. After a fixed number of wait states it returns the response on a second valid/ready channel. It sits between the core's memory stage and the on-chip data RAM.

## Interface
- `ADDR_W`, 12: byte-address bits used. Depth is 2^(ADDR_W-2) 32-bit words. Higher address bits are ignored, so addresses wrap.
- `LATENCY`, 2: wait cycles from request acceptance to response. Legal range is 1..7.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: high only in IDLE.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_addr`  in  32: byte address.
- `req_funct3`  in  3: load/store `funct3`.
- `req_wdata`  in  32: store data, LSB-aligned.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: core accepts the response.
- `rsp_rdata`  out  32: load result after extension. 0 for stores and errors.
- `rsp_err`  out  1: illegal `funct3` or trapped misalignment.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, capture `we`/`addr`/`funct3`/`wdata`, load the wait counter with LATENCY-1, go to WAIT.
  - WAIT: counter decrements each cycle. At 0, perform the access, register `rsp_*`, go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- Only one request is outstanding at a time. A request presented outside IDLE is ignored; the initiator must keep it asserted.
- Store sizes, with byte lanes selected by `addr[1:0]`:
  - 000 SB writes one byte from `wdata[7:0]`.
  - 001 SH writes a halfword from `wdata[15:0]`.
  - 010 SW writes the full word.
  - Any other store `funct3` sets `err` and writes nothing.
- Load sizes:
  - 000 LB and 001 LH are sign-extended.
  - 100 LBU and 101 LHU are zero-extended.
  - 010 LW returns the full word.
  - 011, 110 and 111 set `err`, return rdata 0 and perform no access.
- Misalignment is a halfword access with `addr[0]`=1, or a word access with `addr[1:0]`≠0. Handling is selected under Configuration.
- The memory array is not reset. Its contents survive `rst_n`.
- Asynchronous reset at any point returns the FSM to IDLE and clears `rsp_valid`, `rsp_rdata` and `rsp_err`. A store still in WAIT is discarded and never written.

## Timing
- Output values while reset is held: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Acceptance edge E0 is the edge where `req_valid`&`req_ready` are both high. `req_ready` falls after E0.
- The array write/read happens at edge E0+LATENCY. `rsp_valid` is high from that edge.
- `rsp_*` hold stable while `rsp_valid`&!`rsp_ready`.
- The handshake edge (`rsp_valid`&`rsp_ready`) returns the FSM to IDLE. `req_ready` is 1 in the following cycle, so there is one bubble per transaction.
- Throughput is one transaction per LATENCY+2 cycles, assuming `rsp_ready` is held high.

## Configuration
- `DATA_MEM_MISALIGN_TRAP_EN` defined:
  - A misaligned access sets `rsp_err`=1 and returns `rsp_rdata`=0.
  - No write occurs.
- `DATA_MEM_MISALIGN_TRAP_EN` not defined:
  - Low address bits are forced to the access size: `addr[0]` is cleared for halfwords, `addr[1:0]` for words.
  - The access completes normally with `rsp_err`=0.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata 0xDEADBEEF, err 0. `rsp_valid` is first high exactly LATENCY cycles after E0.
- SB 0x80 @0x13 -> LB 0xFFFFFF80, LBU 0x00000080, LW @0x10 0x80ADBEEF.
- SH 0x8001 @0x12 -> LH 0xFFFF8001, LHU 0x00008001.
- Load with `funct3`=011 -> err 1, rdata 0. LW @0x11 with the macro -> err 1, rdata 0. LW @0x11 without the macro -> rdata is the word at 0x10, err 0.
- Hold `rsp_ready` low for 5 cycles with a second `req_valid` asserted -> `rsp_*` stable, `req_ready` 0, second request accepted only one cycle after the handshake.
- LATENCY=3: pull `rst_n` low 1 cycle after E0 of SW 0x12345678 @0x20 -> `rsp_valid` 0. A following LW @0x20 returns the pre-reset contents.
